// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv_core load/store unit.
// Holds the access-size, error-code and LSU state encodings, plus a
// helper that decides whether an access is misaligned for its size.
package riscv_pkg;

    localparam int LSU_BE_WIDTH = 4;
    localparam int LSU_WORD     = 32;

    typedef enum logic [1:0] {
        LSU_SIZE_B   = 2'b00,
        LSU_SIZE_H   = 2'b01,
        LSU_SIZE_W   = 2'b10,
        LSU_SIZE_ILL = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_ERR_NONE     = 2'b00,
        LSU_ERR_MISALIGN = 2'b01,
        LSU_ERR_SIZE     = 2'b10,
        LSU_ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_ERR  = 2'b11
    } lsu_state_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_SIZE_H: mis = addr_lo[0];
            LSU_SIZE_W: mis = (addr_lo != 2'b00);
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the LSU.
// Ports: addr_lo_i (byte offset in word), size_i (lsu_size_t), unsigned_i,
//        wdata_i (low-aligned store data), rdata_i (raw memory word) in;
//        be_o (byte enables), wdata_o (replicated store data),
//        rdata_o (shifted and sign/zero-extended load data) out.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]              addr_lo_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic [LSU_WORD-1:0]     wdata_i,
    input  logic [LSU_WORD-1:0]     rdata_i,
    output logic [LSU_BE_WIDTH-1:0] be_o,
    output logic [LSU_WORD-1:0]     wdata_o,
    output logic [LSU_WORD-1:0]     rdata_o
);

    logic [LSU_WORD-1:0] shifted_s;

    // Byte enables, store replication and load extension per access size.
    always_comb begin
        shifted_s = rdata_i >> {addr_lo_i, 3'b000};
        be_o      = 4'b0000;
        wdata_o   = 32'h0000_0000;
        rdata_o   = 32'h0000_0000;
        case (lsu_size_t'(size_i))
            LSU_SIZE_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h00_0000, shifted_s[7:0]}
                                     : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            LSU_SIZE_H: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0000, shifted_s[15:0]}
                                     : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            LSU_SIZE_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted_s;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one access from the core, runs a single
// outstanding req/gnt/rvalid transaction on the data-memory port and
// returns a registered one-cycle response.
// Ports: clk_i/rst_i (sync active-high); req_* core request side with
// req_ready_o; resp_* registered response (valid pulse, data, error code);
// mem_* data-memory port (req held until gnt, then wait for rvalid).
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [WORD_SIZE-1:0] req_addr_i,
    input  logic [WORD_SIZE-1:0] req_wdata_i,
    output logic                 resp_valid_o,
    output logic [WORD_SIZE-1:0] resp_rdata_o,
    output logic [1:0]           resp_err_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 we_q, we_d;
    logic                 uns_q, uns_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
    lsu_err_t             resp_err_q, resp_err_d;

    logic [3:0]           be_s;
    logic [WORD_SIZE-1:0] wrep_s;
    logic [WORD_SIZE-1:0] rext_s;
    logic                 in_req_s;

    riscv_lsu_align u_align (
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata_i),
        .be_o       (be_s),
        .wdata_o    (wrep_s),
        .rdata_o    (rext_s)
    );

    // Next-state, request latching, timeout counting and response generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = LSU_ERR_NONE;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    we_d    = req_we_i;
                    uns_d   = req_unsigned_i;
                    cnt_d   = '0;
                    // Error responses are raised straight away so the pulse
                    // coincides with the single ERR cycle.
                    if (lsu_size_t'(req_size_i) == LSU_SIZE_ILL) begin
                        state_d      = LSU_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = LSU_ERR_SIZE;
                    end else if (is_misaligned(lsu_size_t'(req_size_i), req_addr_i[1:0])) begin
                        state_d      = LSU_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = LSU_ERR_MISALIGN;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_ERR: begin
                state_d = LSU_IDLE;
            end
            LSU_REQ: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    state_d      = LSU_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0000_0000 : rext_s;
                end else if (mem_gnt_i) begin
                    state_d = LSU_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = LSU_REQ;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d      = LSU_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0000_0000 : rext_s;
                    cnt_d        = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th WAIT cycle without rvalid.
                    state_d      = LSU_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = LSU_ERR_TIMEOUT;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LSU_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= LSU_ERR_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory-side controls only carry data while a request is on the bus.
    assign in_req_s     = (state_q == LSU_REQ);
    assign req_ready_o  = (state_q == LSU_IDLE);
    assign mem_req_o    = in_req_s;
    assign mem_addr_o   = {addr_q[WORD_SIZE-1:2], 2'b00};
    assign mem_we_o     = in_req_s & we_q;
    assign mem_be_o     = in_req_s ? be_s : 4'b0000;
    assign mem_wdata_o  = in_req_s ? wrep_s : 32'h0000_0000;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (built with TIMEOUT_CYCLES=4).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [1:0]  resp_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int vec_cnt = 0;
    int err_cnt = 0;

    riscv_lsu #(.WORD_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick();
        vec_cnt++;
        if ({mem_req_o, mem_we_o, mem_be_o, resp_valid_o, resp_err_o, req_ready_o} !== 10'b0000000001) begin
            $display("FAIL reset_ctrl: got req=%b we=%b be=%b rv=%b err=%b rdy=%b want 0 0 0000 0 00 1",
                     mem_req_o, mem_we_o, mem_be_o, resp_valid_o, resp_err_o, req_ready_o);
            err_cnt++;
        end
        vec_cnt++;
        if ({mem_addr_o, mem_wdata_o, resp_rdata_o} !== 96'h0) begin
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0",
                     mem_addr_o, mem_wdata_o, resp_rdata_o);
            err_cnt++;
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_store_byte;
        drive_req(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CCDD);
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_1000 || mem_addr_o !== 32'h0000_1000 ||
                mem_wdata_o !== 32'hDDDD_DDDD || resp_valid_o !== 1'b0) begin
                $display("FAIL sb_req_cycle%0d: got req=%b we=%b be=%b addr=%h wdata=%h rv=%b want 1 1 1000 00001000 dddddddd 0",
                         c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, resp_valid_o);
                err_cnt++;
            end
            if (c == 2) mem_gnt_i = 1'b1;
            tick();
        end
        mem_gnt_i = 1'b0;
        vec_cnt++;
        if (mem_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            $display("FAIL sb_wait: got req=%b rv=%b want 0 0", mem_req_o, resp_valid_o);
            err_cnt++;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        tick();
        mem_rvalid_i = 1'b0;
        vec_cnt++;
        if (resp_valid_o !== 1'b1 || resp_err_o !== 2'b00 || resp_rdata_o !== 32'h0) begin
            $display("FAIL sb_resp: got rv=%b err=%b rdata=%h want 1 00 00000000",
                     resp_valid_o, resp_err_o, resp_rdata_o);
            err_cnt++;
        end
        tick();
        vec_cnt++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            $display("FAIL sb_pulse_end: got rv=%b rdy=%b want 0 1", resp_valid_o, req_ready_o);
            err_cnt++;
        end
    endtask

    localparam logic [31:0] LA [5] = '{32'h2002, 32'h2002, 32'h2001, 32'h2003, 32'h2000};
    localparam logic [1:0]  LS [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    localparam logic        LU [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [3:0]  LB [5] = '{4'b1100, 4'b1100, 4'b0010, 4'b1000, 4'b1111};
    localparam logic [31:0] LX [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0012,
                                       32'hFFFF_FF80, 32'h8001_1234};

    task automatic test_load_extend;
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b0, LS[i], LU[i], LA[i], 32'hFFFF_FFFF);
            tick();
            req_valid_i = 1'b0;
            vec_cnt++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== LB[i] || resp_valid_o !== 1'b0) begin
                $display("FAIL load%0d_req: got req=%b we=%b be=%b rv=%b want 1 0 %b 0",
                         i, mem_req_o, mem_we_o, mem_be_o, resp_valid_o, LB[i]);
                err_cnt++;
            end
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h8001_1234;
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            vec_cnt++;
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== LX[i] || resp_err_o !== 2'b00) begin
                $display("FAIL load%0d_resp: got rv=%b rdata=%h err=%b want 1 %h 00",
                         i, resp_valid_o, resp_rdata_o, resp_err_o, LX[i]);
                err_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_errors;
        // Misaligned word, then illegal size.
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, (i == 0) ? 2'b10 : 2'b11, 1'b0,
                      (i == 0) ? 32'h0000_3001 : 32'h0000_3000, 32'h0);
            tick();
            req_valid_i  = 1'b0;
            mem_rvalid_i = 1'b1;
            vec_cnt++;
            if (resp_valid_o !== 1'b1 || resp_err_o !== ((i == 0) ? 2'b01 : 2'b10) ||
                mem_req_o !== 1'b0 || resp_rdata_o !== 32'h0 || req_ready_o !== 1'b0) begin
                $display("FAIL err%0d_resp: got rv=%b err=%b req=%b rdata=%h rdy=%b want 1 %b 0 0 0",
                         i, resp_valid_o, resp_err_o, mem_req_o, resp_rdata_o, req_ready_o,
                         (i == 0) ? 2'b01 : 2'b10);
                err_cnt++;
            end
            tick();
            mem_rvalid_i = 1'b0;
            vec_cnt++;
            if (resp_valid_o !== 1'b0 || mem_req_o !== 1'b0 || req_ready_o !== 1'b1) begin
                $display("FAIL err%0d_after: got rv=%b req=%b rdy=%b want 0 0 1",
                         i, resp_valid_o, mem_req_o, req_ready_o);
                err_cnt++;
            end
            tick();
            vec_cnt++;
            if (resp_valid_o !== 1'b0) begin
                $display("FAIL err%0d_ignored_rvalid: got rv=%b want 0", i, resp_valid_o);
                err_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        tick();
        req_valid_i  = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0001;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        pulses += int'(resp_valid_o);
        vec_cnt++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCAFE_0001 || req_ready_o !== 1'b1) begin
            $display("FAIL b2b_first: got rv=%b rdata=%h rdy=%b want 1 cafe0001 1",
                     resp_valid_o, resp_rdata_o, req_ready_o);
            err_cnt++;
        end
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0);
        tick();
        req_valid_i = 1'b0;
        pulses += int'(resp_valid_o);
        vec_cnt++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_6004 || resp_valid_o !== 1'b0) begin
            $display("FAIL b2b_second_req: got req=%b addr=%h rv=%b want 1 00006004 0",
                     mem_req_o, mem_addr_o, resp_valid_o);
            err_cnt++;
        end
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0002;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        pulses += int'(resp_valid_o);
        vec_cnt++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCAFE_0002) begin
            $display("FAIL b2b_second: got rv=%b rdata=%h want 1 cafe0002", resp_valid_o, resp_rdata_o);
            err_cnt++;
        end
        tick();
        pulses += int'(resp_valid_o);
        vec_cnt++;
        if (pulses != 2) begin
            $display("FAIL b2b_pulse_count: got %0d want 2", pulses);
            err_cnt++;
        end
    endtask

    task automatic test_timeout;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            vec_cnt++;
            if (resp_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
                $display("FAIL tmo_wait%0d: got rv=%b req=%b want 0 0", w, resp_valid_o, mem_req_o);
                err_cnt++;
            end
            if (w < 4) tick();
        end
        tick();
        vec_cnt++;
        if (resp_valid_o !== 1'b1 || resp_err_o !== 2'b11 || resp_rdata_o !== 32'h0) begin
            $display("FAIL tmo_resp: got rv=%b err=%b rdata=%h want 1 11 00000000",
                     resp_valid_o, resp_err_o, resp_rdata_o);
            err_cnt++;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        vec_cnt++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            $display("FAIL tmo_late_rvalid: got rv=%b rdy=%b want 0 1", resp_valid_o, req_ready_o);
            err_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        tick();
        rst_i = 1'b0;
        vec_cnt++;
        if ({mem_req_o, mem_we_o, mem_be_o, resp_valid_o, resp_err_o, req_ready_o} !== 10'b0000000001 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || resp_rdata_o !== 32'h0) begin
            $display("FAIL rst_mid: got req=%b rv=%b rdy=%b addr=%h want 0 0 1 00000000",
                     mem_req_o, resp_valid_o, req_ready_o, mem_addr_o);
            err_cnt++;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        tick();
        mem_rvalid_i = 1'b0;
        vec_cnt++;
        if (resp_valid_o !== 1'b0) begin
            $display("FAIL rst_stale_rvalid: got rv=%b want 0", resp_valid_o);
            err_cnt++;
        end
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h1122_3344);
        tick();
        req_valid_i = 1'b0;
        vec_cnt++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b1111 ||
            mem_wdata_o !== 32'h1122_3344 || mem_addr_o !== 32'h0000_5004) begin
            $display("FAIL sw_req: got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 1111 11223344 00005004",
                     mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o);
            err_cnt++;
        end
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        vec_cnt++;
        if (resp_valid_o !== 1'b1 || resp_err_o !== 2'b00 || resp_rdata_o !== 32'h0) begin
            $display("FAIL sw_resp: got rv=%b err=%b rdata=%h want 1 00 00000000",
                     resp_valid_o, resp_err_o, resp_rdata_o);
            err_cnt++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_extend();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit directly downstream of the ALU in riscv_core. It consumes the computed effective address and store data and drives the data-memory port.
Each access runs as a single-outstanding req/gnt/rvalid transaction. The unit generates byte enables, replicates store data, and aligns and sign/zero-extends load data.
Misaligned accesses, illegal sizes and memory timeouts are reported to the core as error responses instead of being issued to memory.

Parameters:
WORD_SIZE, 32, data/address width in bits; only 32 is supported.
TIMEOUT_CYCLES, 255, maximum cycles in WAIT before the access is aborted with a timeout error; must be >= 1.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
req_valid_i  input  1  core has an access to issue
req_ready_o  output  1  LSU can accept a request (high only in IDLE)
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  riscv_pkg::lsu_size_t: 00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  load zero-extends when 1 (LBU/LHU)
req_addr_i  input  WORD_SIZE  byte address from ALU result
req_wdata_i  input  WORD_SIZE  store data, low-aligned
resp_valid_o  output  1  one-cycle pulse: access complete
resp_rdata_o  output  WORD_SIZE  extended load data; 0 for stores and errors
resp_err_o  output  2  riscv_pkg::lsu_err_t: 00 none, 01 misaligned, 10 illegal size, 11 timeout
mem_req_o  output  1  memory request, held until granted
mem_gnt_i  input  1  memory accepted the request
mem_addr_o  output  WORD_SIZE  word-aligned address ({addr[31:2],2'b00})
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_wdata_o  output  WORD_SIZE  replicated store data
mem_rvalid_i  input  1  response for loads and store-acks
mem_rdata_i  input  WORD_SIZE  raw read word

Behaviour:
- States: IDLE, REQ, WAIT, ERR (riscv_pkg::lsu_state_t).
- Reset: rst_i high at an edge forces state IDLE, clears all registers and the timeout counter. This applies from any state, including mid-transaction. After that edge: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=00, req_ready_o=1.
- IDLE: req_ready_o=1. Accept when req_valid_i=1 and register addr, size, we, unsigned and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) -> ERR, code 01.
  - size 11 -> ERR, code 10.
  - Otherwise -> REQ.
- ERR: no memory activity. resp_valid_o=1 with the latched code for exactly one cycle, then IDLE.
- REQ: mem_req_o=1; addr, we, be and wdata stay stable until mem_gnt_i.
  - gnt=1 and rvalid=0 -> WAIT.
  - gnt=1 and rvalid=1 in the same cycle -> complete immediately.
- WAIT: mem_req_o=0. The counter increments every cycle.
  - rvalid -> complete.
  - Counter reaches TIMEOUT_CYCLES without rvalid -> response with code 11, then IDLE.
- Complete: on the next edge, state returns to IDLE and a registered one-cycle resp_valid_o is raised with resp_rdata_o.
  - Latency, zero-wait memory: accept edge -> mem_req_o high next cycle -> resp_valid_o the cycle after gnt/rvalid, i.e. 2 cycles after acceptance.
  - A new request may be accepted in the same cycle resp_valid_o is high.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load data: shift rdata right by 8*addr[1:0], take 8/16/32 bits, then sign-extend, or zero-extend when req_unsigned_i=1.
- Stores: resp_rdata_o=0, and the access still waits for rvalid (store ack).
- Dropped inputs: mem_rvalid_i in IDLE or ERR is ignored (late response after timeout). So is rvalid in REQ without gnt. req_valid_i outside IDLE is not accepted.

Decomposition:
- riscv_pkg holds:
  - lsu_size_t
  - lsu_err_t
  - lsu_state_t
  - constant LSU_BE_WIDTH = 4
- Sub-module riscv_lsu_align (combinational): addr[1:0], size, unsigned, wdata and rdata in; be, replicated wdata and extended rdata out.
- The FSM, timeout counter and registers stay in riscv_lsu.

Test Plan:
1. SB, addr 0x1003, wdata 0xAABBCCDD; gnt after 2 cycles, rvalid next cycle -> mem_addr 0x1000, be 4'b1000, mem_wdata 0xDDDDDDDD, mem_req held 3 cycles; then resp_valid 1 cycle, err 00, rdata 0.
2. LH addr 0x2002, mem_rdata 0x80011234 with gnt+rvalid same cycle -> rdata 0xFFFF8001, resp_valid 2 cycles after accept. Repeat as LHU -> 0x00008001. LBU addr 0x2001 -> 0x00000012.
3. LW addr 0x3001 -> mem_req never asserted, resp_valid next cycle with err 01. Size 11 -> err 10.
4. Back-to-back: second LW issued in the resp_valid cycle of the first, zero-wait memory -> accepted the same cycle, one response every 2 cycles, no lost or duplicated pulses.
5. TIMEOUT_CYCLES=4, gnt given, rvalid withheld -> resp_valid with err 11 after 4 WAIT cycles. A late rvalid in IDLE produces no response.
6. rst_i asserted one cycle in WAIT -> next cycle all outputs at reset values, req_ready_o=1. The stale rvalid is ignored and a fresh SW completes normally.
